// File: rtl/exe_mem_stage_reg.sv
// EXE->MEM pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and bubble masking of the WB/MEM control bits.
module exe_mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] st_val_in,
  input  logic [ADDR_W-1:0] dest_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] st_val,
  output logic [ADDR_W-1:0] dest,
  output logic [1:0]        occupancy
);

  localparam int REC_W = 3 + 3*DATA_W + ADDR_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_p0, state_nxt;
  logic [REC_W-1:0]  head_p0, skid_p0;
  logic [REC_W-1:0]  head_nxt, skid_nxt;
  logic [REC_W-1:0]  in_rec;
  logic              accept, fire;
  logic              head_wb, head_mr, head_mw;

  assign in_rec    = {wb_en_in, mem_r_en_in, mem_w_en_in, pc_in, alu_result_in, st_val_in, dest_in};
  assign out_valid = (state_p0 != EMPTY);
  // Skid mode keeps in_ready a pure function of registered state so MEM's
  // ready never reaches EXE combinationally.
  assign in_ready  = (SKID != 0) ? (state_p0 != TWO) : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;

  always_comb begin
    state_nxt = state_p0;
    head_nxt  = head_p0;
    skid_nxt  = skid_p0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            head_nxt  = in_rec;
          end
        end
        ONE: begin
          // Without skid, accept while ONE implies out_ready, so only the
          // first branch is reachable there.
          if (accept && fire) begin
            head_nxt  = in_rec;
          end else if (accept) begin
            state_nxt = TWO;
            skid_nxt  = in_rec;
          end else if (fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (fire) begin
            state_nxt = ONE;
            head_nxt  = skid_p0;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Stage boundary: EXE -> MEM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= EMPTY;
      head_p0  <= '0;
      skid_p0  <= '0;
    end else begin
      state_p0 <= state_nxt;
      head_p0  <= head_nxt;
      skid_p0  <= skid_nxt;
    end
  end

  assign {head_wb, head_mr, head_mw, pc, alu_result, st_val, dest} = head_p0;
  assign wb_en    = head_wb && out_valid;
  assign mem_r_en = head_mr && out_valid;
  assign mem_w_en = head_mw && out_valid;

  always_comb begin
    occupancy = 2'd0;
    case (state_p0)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
// Directed bench for exe_mem_stage_reg: skid instance with a FIFO scoreboard,
// plus a single-entry instance for the combinational-ready mode.
module tb_exe_mem_stage_reg;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Skid instance signals
  logic          in_valid1 = 0, out_ready1 = 0, flush1 = 0;
  logic          wb_in1 = 0, mr_in1 = 0, mw_in1 = 0;
  logic [DW-1:0] pc_in1 = 0, alu_in1 = 0, st_in1 = 0;
  logic [AW-1:0] dest_in1 = 0;
  logic          in_ready1, out_valid1, wb1, mr1, mw1;
  logic [DW-1:0] pc1, alu1, st1;
  logic [AW-1:0] dest1;
  logic [1:0]    occ1;

  // Single-entry instance signals
  logic          in_valid0 = 0, out_ready0 = 0, flush0 = 0;
  logic [DW-1:0] alu_in0 = 0;
  logic          in_ready0, out_valid0, wb0, mr0, mw0;
  logic [DW-1:0] pc0, alu0, st0;
  logic [AW-1:0] dest0;
  logic [1:0]    occ0;

  exe_mem_stage_reg #(.DATA_W(DW), .ADDR_W(AW), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .wb_en_in(wb_in1), .mem_r_en_in(mr_in1), .mem_w_en_in(mw_in1),
    .pc_in(pc_in1), .alu_result_in(alu_in1), .st_val_in(st_in1), .dest_in(dest_in1),
    .flush(flush1), .out_valid(out_valid1), .out_ready(out_ready1),
    .wb_en(wb1), .mem_r_en(mr1), .mem_w_en(mw1),
    .pc(pc1), .alu_result(alu1), .st_val(st1), .dest(dest1), .occupancy(occ1)
  );

  exe_mem_stage_reg #(.DATA_W(DW), .ADDR_W(AW), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .wb_en_in(1'b1), .mem_r_en_in(1'b0), .mem_w_en_in(1'b0),
    .pc_in(32'h0), .alu_result_in(alu_in0), .st_val_in(32'h0), .dest_in(5'd0),
    .flush(flush0), .out_valid(out_valid0), .out_ready(out_ready0),
    .wb_en(wb0), .mem_r_en(mr0), .mem_w_en(mw0),
    .pc(pc0), .alu_result(alu0), .st_val(st0), .dest(dest0), .occupancy(occ0)
  );

  int errors = 0;
  int checks = 0;
  logic [AW+DW-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on the skid instance: score any fire/accept, then cross the edge.
  task automatic tick();
    logic [AW+DW-1:0] e;
    @(negedge clk);
    if (out_valid1 && out_ready1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_fire", {27'd0, dest1, alu1}, 64'hDEAD);
      end else begin
        e = sb_q.pop_front();
        chk("sb_alu", alu1, e[DW-1:0]);
        chk("sb_dest", dest1, e[AW+DW-1:DW]);
      end
    end
    if (flush1) sb_q.delete();
    else if (in_valid1 && in_ready1) sb_q.push_back({dest_in1, alu_in1});
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input logic [DW-1:0] a, input logic [AW-1:0] d);
    in_valid1 = v;
    alu_in1   = a;
    dest_in1  = d;
  endtask

  initial begin
    // Reset values, no clock edge yet
    #3;
    chk("rst_out_valid1", out_valid1, 0);
    chk("rst_in_ready1", in_ready1, 1);
    chk("rst_occ1", occ1, 0);
    chk("rst_pc1", pc1, 0);
    chk("rst_alu1", alu1, 0);
    chk("rst_wb1", wb1, 0);
    chk("rst_in_ready0", in_ready0, 1);
    chk("rst_out_valid0", out_valid0, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;

    // Streaming with out_ready held high
    out_ready1 = 1;
    for (int i = 1; i <= 8; i++) begin
      drive1(1'b1, DW'(i), AW'(i));
      tick();
      chk("stream_valid", out_valid1, 1);
      chk("stream_alu", alu1, i);
      chk("stream_occ", occ1, 1);
    end
    drive1(1'b0, 0, 0);
    tick();
    chk("stream_drain", out_valid1, 0);

    // Back-pressure: A, B, C back to back, MEM stalls from cycle 1
    drive1(1'b1, 32'h10, 5'd1);
    tick();
    out_ready1 = 0;
    drive1(1'b1, 32'h20, 5'd2);
    tick();
    chk("bp_occ2", occ1, 2);
    chk("bp_in_ready0", in_ready1, 0);
    drive1(1'b1, 32'h30, 5'd3);
    tick();
    chk("bp_hold_occ", occ1, 2);
    chk("bp_hold_head", alu1, 32'h10);
    out_ready1 = 1;
    tick();
    chk("bp_head_b", alu1, 32'h20);
    chk("bp_occ1", occ1, 1);
    tick();
    chk("bp_head_c", alu1, 32'h30);
    drive1(1'b0, 0, 0);
    tick();
    chk("bp_drained", out_valid1, 0);
    chk("bp_sb_empty", sb_q.size(), 0);

    // Flush with state TWO and an incoming entry
    out_ready1 = 0;
    mw_in1 = 1;
    drive1(1'b1, 32'h40, 5'd1);
    tick();
    drive1(1'b1, 32'h50, 5'd2);
    tick();
    chk("fl_pre_occ", occ1, 2);
    chk("fl_pre_mw", mw1, 1);
    flush1 = 1;
    in_valid1 = 1;
    dest_in1 = 5'd7;
    tick();
    flush1 = 0;
    drive1(1'b0, 0, 0);
    mw_in1 = 0;
    chk("fl_valid", out_valid1, 0);
    chk("fl_occ", occ1, 0);
    chk("fl_mw", mw1, 0);
    chk("fl_in_ready", in_ready1, 1);
    out_ready1 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_dest7", out_valid1, 0);
    end

    // Bubble masking
    wb_in1 = 1;
    mw_in1 = 1;
    st_in1 = 32'hABCD;
    drive1(1'b1, 32'h60, 5'd4);
    tick();
    chk("bm_mw_live", mw1, 1);
    chk("bm_wb_live", wb1, 1);
    drive1(1'b0, 0, 0);
    wb_in1 = 0;
    mw_in1 = 0;
    st_in1 = 32'h0;
    tick();
    chk("bm_valid", out_valid1, 0);
    chk("bm_mw", mw1, 0);
    chk("bm_wb", wb1, 0);
    chk("bm_st_hold", st1, 32'hABCD);

    // Single-entry mode: combinational in_ready
    in_valid0 = 1;
    alu_in0 = 32'h11;
    out_ready0 = 0;
    @(posedge clk);
    #1;
    in_valid0 = 0;
    #1;
    chk("s0_valid", out_valid0, 1);
    chk("s0_ready_low", in_ready0, 0);
    out_ready0 = 1;
    #1;
    chk("s0_ready_comb", in_ready0, 1);
    in_valid0 = 1;
    alu_in0 = 32'h22;
    @(posedge clk);
    #1;
    chk("s0_replace_valid", out_valid0, 1);
    chk("s0_replace_alu", alu0, 32'h22);
    chk("s0_occ", occ0, 1);
    in_valid0 = 0;
    @(posedge clk);
    #1;
    chk("s0_empty", out_valid0, 0);
    chk("s0_occ0", occ0, 0);

    // Asynchronous reset mid-cycle with state TWO
    out_ready1 = 0;
    wb_in1 = 1;
    drive1(1'b1, 32'h70, 5'd5);
    tick();
    drive1(1'b1, 32'h80, 5'd6);
    tick();
    drive1(1'b0, 0, 0);
    chk("ar_pre_occ", occ1, 2);
    #2;
    rst = 1;
    #1;
    chk("ar_valid", out_valid1, 0);
    chk("ar_wb", wb1, 0);
    chk("ar_alu", alu1, 0);
    chk("ar_occ", occ1, 0);
    chk("ar_in_ready", in_ready1, 1);
    sb_q.delete();
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk("ar_after_valid", out_valid1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/exe_mem_stage_reg.md
# exe_mem_stage_reg

Parametrised EXE→MEM pipeline register carrying ALU result, store value, destination register, PC and the WB/MEM control bits. Generalises the plain enable-less stage register with a valid/ready handshake, optional 2-entry skid buffering, synchronous flush, and bubble masking of control bits. It sits between the execute stage and the data-memory stage and lets MEM back-pressure EXE without a combinational ready path when skid mode is enabled.

## Interface
- DATA_W, 32, width of PC, ALU result and store value
- ADDR_W, 5, width of destination register index
- SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single entry (combinational in_ready)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  EXE presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control bits from EXE
- pc_in, alu_result_in, st_val_in  in  DATA_W each  payload from EXE
- dest_in  in  ADDR_W  destination register index
- flush  in  1  synchronous kill of all held and incoming entries
- out_valid  out  1  head entry valid toward MEM
- out_ready  in  1  MEM consumes head this cycle
- wb_en, mem_r_en, mem_w_en  out  1 each  head control bits, masked by out_valid
- pc, alu_result, st_val  out  DATA_W each  head payload
- dest  out  ADDR_W  head destination index
- occupancy  out  2  number of valid entries (0..2; max 1 when SKID=0)

## Operation
- accept = in_valid & in_ready; fire = out_valid & out_ready.
- Entry = {wb_en, mem_r_en, mem_w_en, pc, alu_result, st_val, dest}; stored as one record, order strictly FIFO.
- SKID=1 states: EMPTY, ONE, TWO; head register drives outputs, skid register holds second entry.
  - EMPTY: accept → ONE, head ← in.
  - ONE: accept & fire → ONE, head ← in; accept & !fire → TWO, skid ← in; !accept & fire → EMPTY; else hold.
  - TWO: fire → ONE, head ← skid; else hold. No accept possible.
  - in_ready = (state != TWO), a registered-state function only, never depends on out_ready.
- SKID=0: single head entry; in_ready = !out_valid | out_ready (combinational); accept loads head; fire without accept empties.
- flush: highest priority; next state EMPTY, occupancy 0; incoming entry in same cycle is dropped even if in_valid & in_ready; a fire in the same cycle still counts as consumed by MEM.
- Bubble masking: wb_en, mem_r_en, mem_w_en outputs = stored bit & out_valid. Payload outputs (pc, alu_result, st_val, dest) hold last loaded value when invalid; never X after reset.
- No arithmetic on payload; widths pass through unchanged.

## Timing
- Reset (async assert, sync release irrelevant to state): state EMPTY, out_valid 0, all payload outputs 0, all control outputs 0, occupancy 0, in_ready 1 (both modes).
- Latency: accept in cycle N → out_valid and payload visible after edge N+1 when stage was EMPTY or head fired in N.
- Throughput: 1 entry/cycle sustained when out_ready held 1.
- SKID=1: out_ready deasserting with ONE and accept → TWO; in_ready falls one cycle later (after edge), never within the cycle.
- Simultaneous accept & fire in ONE: head replaced, out_valid stays 1, no bubble.
- Reset mid-stream: all entries lost immediately, outputs return to reset values asynchronously.
- occupancy updates on the same edge as state.

## Test plan
- Reset: assert rst mid-cycle with state TWO → out_valid 0, wb_en 0, alu_result 0, occupancy 0, in_ready 1 without waiting for clk.
- Streaming SKID=1: in_valid=1 for 8 cycles with alu_result_in = 1..8, out_ready=1 → outputs 1..8 on consecutive cycles, one cycle after each accept, occupancy constant 1.
- Back-pressure SKID=1: send A=0x10, B=0x20, C=0x30 back-to-back, out_ready=0 from cycle 1 → occupancy 2, in_ready 0, C held at input; raise out_ready → outputs A, B, C in order, no drop or duplicate.
- Flush: state TWO, flush=1 with in_valid=1 (dest_in=7) → next cycle out_valid 0, occupancy 0, mem_w_en 0; entry with dest 7 never appears.
- SKID=0 mode: out_ready=0 with head valid → in_ready 0 same cycle; out_ready=1 and in_valid=1 same cycle → head replaced next edge, out_valid stays 1.
- Bubble masking: load entry with mem_w_en_in=1, wb_en_in=1, let it fire with no new input → out_valid 0, mem_w_en 0, wb_en 0, st_val retains last value.
